// File: rtl/uart_tx_arb_mux.sv
// uart_tx_arb_mux: multi-channel UART transmit front end.
// Each source channel has a private FIFO. A round-robin arbiter pops one byte
// at a time and hands it to the single UART transmitter using a
// busy / load-strobe / done handshake.
// Optional build macro: UART_TX_ARB_OVF_CNT_EN adds ovf_cnt, which holds one
// saturating 16-bit dropped-byte counter per channel.
//
// state | meaning
// IDLE  | waiting for an idle transmitter and a non-empty channel
// LOAD  | popped byte is presented on uart_tx_data with a one-cycle strobe
// WAIT  | byte owned by the transmitter, waiting for uart_tx_over
`timescale 1ns/1ps

module uart_tx_arb_mux #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int AW     = 8,
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    input  logic              uart_tx_status,
    input  logic              uart_tx_over,
    output logic [DATA_W-1:0] uart_tx_data,
    output logic              uart_tx_data_ready,
    output logic [CW-1:0]     tx_ch,
    output logic [N_CH-1:0]   ch_full,
    output logic [N_CH-1:0]   ch_empty,
    output logic [N_CH-1:0]   ch_ovf,
    input  logic              ovf_clr
`ifdef UART_TX_ARB_OVF_CNT_EN
    ,
    output logic [N_CH*16-1:0] ovf_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW:0]   FULL_DIFF = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   PTR_ONE   = 1;
    // Channel 0 wins the first arbitration after reset.
    localparam logic [CW-1:0] RR_RST    = CW'(N_CH - 1);

    logic [DATA_W-1:0] mem_q [N_CH][DEPTH];

    logic [AW:0]       wptr_q [N_CH];
    logic [AW:0]       wptr_d [N_CH];
    logic [AW:0]       rptr_q [N_CH];
    logic [AW:0]       rptr_d [N_CH];

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     tx_ch_q, tx_ch_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;

    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   empty;

    int                wr_idx;
    logic              wr_ch_ok;
    logic              wr_accept;
    logic              wr_drop;

    int                rr_idx;
    logic              grant_vld;
    logic [CW-1:0]     grant_sel;

    // Per-channel occupancy flags from the registered pointers only, so a
    // same-cycle pop never unblocks a write to a full channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = ((wptr_q[i] - rptr_q[i]) == FULL_DIFF);
        end
    end

    // Write decode: accept, drop on full, or ignore an out-of-range channel.
    always_comb begin
        wr_idx    = 0;
        wr_ch_ok  = 1'b1;
        wr_accept = 1'b0;
        wr_drop   = 1'b0;
        if (N_CH > 1) begin
            wr_idx   = int'(wr_ch);
            wr_ch_ok = (wr_idx < N_CH);
            if (!wr_ch_ok) begin
                wr_idx = 0;
            end
        end
        if (wr_en && wr_ch_ok) begin
            if (full[wr_idx]) begin
                wr_drop = 1'b1;
            end else begin
                wr_accept = 1'b1;
            end
        end
    end

    // Round-robin pick: the first non-empty channel after rr_q, circularly.
    // The loop runs from the farthest candidate to the nearest, so the last
    // match found is the nearest one.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = rr_q;
        rr_idx    = 0;
        for (int i = N_CH; i >= 1; i--) begin
            rr_idx = (int'(rr_q) + i) % N_CH;
            if (!empty[rr_idx]) begin
                grant_vld = 1'b1;
                grant_sel = CW'(rr_idx);
            end
        end
    end

    // Next-state logic for the FSM, the FIFO pointers and the output registers.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        pop_data_d = pop_data_q;
        tx_data_d  = tx_data_q;
        tx_ch_d    = tx_ch_q;
        tx_ready_d = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
        end

        if (wr_accept) begin
            wptr_d[wr_idx] = wptr_q[wr_idx] + PTR_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!uart_tx_status && grant_vld) begin
                    grant_d            = grant_sel;
                    rr_d               = grant_sel;
                    pop_data_d         = mem_q[grant_sel][rptr_q[grant_sel][AW-1:0]];
                    rptr_d[grant_sel]  = rptr_q[grant_sel] + PTR_ONE;
                    state_d            = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d  = pop_data_q;
                tx_ch_d    = grant_q;
                tx_ready_d = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart_tx_over) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow flags: a new drop overrides a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end
        if (wr_drop) begin
            ovf_d[wr_idx] = 1'b1;
        end
    end

    // FIFO storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_idx][wptr_q[wr_idx][AW-1:0]] <= wr_data;
        end
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= RR_RST;
            grant_q    <= '0;
            pop_data_q <= '0;
            tx_data_q  <= '0;
            tx_ch_q    <= '0;
            tx_ready_q <= 1'b0;
            ovf_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            pop_data_q <= pop_data_d;
            tx_data_q  <= tx_data_d;
            tx_ch_q    <= tx_ch_d;
            tx_ready_q <= tx_ready_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

`ifdef UART_TX_ARB_OVF_CNT_EN
    logic [15:0] cnt_q [N_CH];
    logic [15:0] cnt_d [N_CH];

    // Saturating per-channel drop counters; a clear beats a same-cycle drop.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ovf_clr) begin
                cnt_d[i] = '0;
            end else if (wr_drop && (wr_idx == i) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack the counters with channel 0 in the LSBs.
    always_comb begin
        ovf_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            ovf_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

    assign uart_tx_data       = tx_data_q;
    assign uart_tx_data_ready = tx_ready_q;
    assign tx_ch              = tx_ch_q;
    assign ch_full            = full;
    assign ch_empty           = empty;
    assign ch_ovf             = ovf_q;

endmodule
